// File: rtl/ras_pkg.sv
// Shared front-end decode constants and helpers for the return address stack
// and its neighbours (BTB, direction predictor).
package ras_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  // Per-cycle stack action, in descending priority order.
  typedef enum logic [2:0] {
    UPD_FLUSH,
    UPD_STALL,
    UPD_SAME,
    UPD_PUSH,
    UPD_POP,
    UPD_IDLE
  } upd_e;

  // A return is `jr rs` with rs equal to the link register.
  function automatic logic is_ret(input logic [31:0] instr, input logic [4:0] ra_reg);
    return (instr[31:26] == OPC_SPECIAL) &&
           (instr[5:0]   == FUNCT_JR)    &&
           (instr[25:21] == ra_reg);
  endfunction

endpackage

// File: rtl/ras_ckpt_if.sv
// Front-end to RAS signal bundle: decode/push inputs, flush checkpoint
// restore, and the prediction plus checkpoint-source outputs.
interface ras_ckpt_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
);

  logic             stall;
  logic [31:0]      if_instr;
  logic [31:0]      id_pc;
  logic             is_link;
  logic             flush;
  logic [PTR_W-1:0] flush_ptr;
  logic [PTR_W:0]   flush_cnt;

  logic             hit;
  logic [31:0]      alt_pc;
  logic [PTR_W-1:0] tos_ptr;
  logic [PTR_W:0]   count;
  logic             ovf;

  modport master (
    output stall, if_instr, id_pc, is_link, flush, flush_ptr, flush_cnt,
    input  hit, alt_pc, tos_ptr, count, ovf
  );

  modport slave (
    input  stall, if_instr, id_pc, is_link, flush, flush_ptr, flush_cnt,
    output hit, alt_pc, tos_ptr, count, ovf
  );

endinterface

// File: rtl/ras_circ_stack.sv
// Circular DEPTH x 32 return-address storage: one synchronous write port and
// an asynchronous read of the entry selected by the top-of-stack pointer.
module ras_circ_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: entries are reset so a prediction read from an empty stack is a
  // defined 0; this forces flops rather than a RAM macro, which is fine at
  // this depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ras_ckpt.sv
// Return address stack with wrap-around overwrite, same-cycle call/return
// bypass, and pointer/count checkpoint restore on front-end flush.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int RA_REG   = 31,
  parameter int LINK_OFS = 8
) (
  input  logic       clk,
  input  logic       reset,
  ras_ckpt_if.slave  bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] tos_ptr_q, tos_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             ovf_q,     ovf_d;

  logic             ret;
  logic             same;
  logic             hit;
  logic             full;
  logic             empty;
  logic [31:0]      link_addr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [31:0]      top_data;
  logic             we;
  upd_e             upd;

  assign ret       = is_ret(bus.if_instr, 5'(RA_REG));
  assign same      = ret & bus.is_link;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign hit       = ret & (~empty | bus.is_link);
  assign link_addr = bus.id_pc + 32'(LINK_OFS);
  assign ptr_inc   = tos_ptr_q + PTR_W'(1);
  assign ptr_dec   = tos_ptr_q - PTR_W'(1);

  // Flush outranks stall: a checkpoint restore must land even while frozen.
  always_comb begin
    if (bus.flush)                    upd = UPD_FLUSH;
    else if (bus.stall)               upd = UPD_STALL;
    else if (same)                    upd = UPD_SAME;
    else if (bus.is_link)             upd = UPD_PUSH;
    else if (hit)                     upd = UPD_POP;
    else                              upd = UPD_IDLE;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    tos_ptr_d = tos_ptr_q;
    count_d   = count_q;
    ovf_d     = 1'b0;
    we        = 1'b0;
    unique case (upd)
      UPD_FLUSH: begin
        tos_ptr_d = bus.flush_ptr;
        count_d   = (bus.flush_cnt > CNT_FULL) ? CNT_FULL : bus.flush_cnt;
      end
      UPD_PUSH: begin
        tos_ptr_d = ptr_inc;
        we        = 1'b1;
        count_d   = full ? count_q : count_q + CNT_W'(1);
        ovf_d     = full;
      end
      UPD_POP: begin
        tos_ptr_d = ptr_dec;
        count_d   = count_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_ptr_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      tos_ptr_q <= tos_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  ras_circ_stack #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .waddr_i (ptr_inc),
    .wdata_i (link_addr),
    .raddr_i (tos_ptr_q),
    .rdata_o (top_data)
  );

  assign bus.hit     = hit;
  assign bus.alt_pc  = same ? link_addr : top_data;
  assign bus.tos_ptr = tos_ptr_q;
  assign bus.count   = count_q;
  assign bus.ovf     = ovf_q;

endmodule
